// File: rtl/double_up_dealer_pkg.sv
// Shared types and constants for the high/low double-up dealer.
package double_up_dealer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAW0  = 3'd1,
    ST_SHOW   = 3'd2,
    ST_DRAW1  = 3'd3,
    ST_ISSUE  = 3'd4,
    ST_WAIT_J = 3'd5
  } dealer_state_t;

  localparam logic [1:0]  HL_HIGH   = 2'b01;
  localparam logic [1:0]  HL_LOW    = 2'b10;
  localparam logic [3:0]  CARD_MIN  = 4'd1;
  localparam logic [3:0]  CARD_MAX  = 4'd13;
  // Fibonacci taps 16,14,13,11 -> register bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic card_in_range(input logic [3:0] c);
    return (c >= CARD_MIN) && (c <= CARD_MAX);
  endfunction

  function automatic logic choice_is_legal(input logic [1:0] c);
    return (c == HL_HIGH) || (c == HL_LOW);
  endfunction

endpackage

// File: rtl/double_up_dealer_card_lfsr.sv
// Free-running card source: 16-bit Fibonacci LFSR plus a 1..13 candidate filter.
module card_lfsr
  import double_up_dealer_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] card,
  output logic       card_valid
);

  logic [15:0] lfsr;

  // Shift every cycle regardless of dealer state; reset reloads the seed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign card       = lfsr[3:0];
  assign card_valid = card_in_range(lfsr[3:0]);

endmodule

// File: rtl/double_up_dealer.sv
// Double-up dealer: deals shown/hidden cards, issues the high/low pulse, chains rounds.
module double_up_dealer
  import double_up_dealer_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bet_c,
  input  logic       deal,
  input  logic       choice_valid,
  input  logic [1:0] choice,
  input  logic       dchance2,
  output logic [3:0] Dnum0,
  output logic [3:0] Dnum1,
  output logic [1:0] highlow,
  output logic       awaiting_choice,
  output logic       round_done
);

  dealer_state_t state;
  logic [1:0]    choice_q;
  logic [3:0]    card;
  logic          card_valid;

  card_lfsr #(.SEED(SEED)) u_lfsr (
    .clock      (clock),
    .reset      (reset),
    .card       (card),
    .card_valid (card_valid)
  );

  // FSM, card registers and choice latch; all outputs registered.
  // highlow/round_done default to zero each cycle so they can only pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      choice_q        <= '0;
      Dnum0           <= '0;
      Dnum1           <= '0;
      highlow         <= '0;
      awaiting_choice <= 1'b0;
      round_done      <= 1'b0;
    end else if (!bet_c) begin
      state           <= ST_IDLE;
      choice_q        <= '0;
      Dnum0           <= '0;
      Dnum1           <= '0;
      highlow         <= '0;
      awaiting_choice <= 1'b0;
      round_done      <= 1'b0;
    end else begin
      highlow    <= '0;
      round_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (deal) begin
            state <= ST_DRAW0;
          end
        end
        ST_DRAW0: begin
          if (card_valid) begin
            Dnum0           <= card;
            awaiting_choice <= 1'b1;
            state           <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (choice_valid && choice_is_legal(choice)) begin
            choice_q        <= choice;
            awaiting_choice <= 1'b0;
            state           <= ST_DRAW1;
          end
        end
        ST_DRAW1: begin
          if (card_valid) begin
            Dnum1   <= card;
            highlow <= choice_q;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT_J;
        end
        ST_WAIT_J: begin
          if (dchance2) begin
            Dnum0           <= Dnum1;
            Dnum1           <= '0;
            awaiting_choice <= 1'b1;
            state           <= ST_SHOW;
          end else begin
            Dnum0      <= '0;
            Dnum1      <= '0;
            choice_q   <= '0;
            round_done <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
